// File: rtl/tie_cfg_bank_if.sv
// Write-port bundle for tie_cfg_bank: valid/ready handshake carrying a channel
// index and the shadow value to store there.
interface tie_cfg_bank_if #(
  parameter int ADDR_W = 2,
  parameter int WIDTH  = 8
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/tie_cfg_bank.sv
// Programmable bank of CHANNELS x WIDTH glitch-free tie-off constants with a shadow/commit
// write port and a one-way lock. Define TIE_CFG_PARITY_EN to add registered per-channel parity (par_out).
module tie_cfg_bank #(
  parameter int               WIDTH       = 8,
  parameter int               CHANNELS    = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              ADDR_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      ck,
  input  logic                      rst,
  tie_cfg_bank_if.slave             wr,
  input  logic                      commit,
  input  logic                      lock,
  output logic                      locked,
  output logic                      dirty,
`ifdef TIE_CFG_PARITY_EN
  output logic [CHANNELS-1:0]       par_out,
`endif
  output logic [CHANNELS*WIDTH-1:0] tie_out
);

  typedef enum logic [1:0] {S_OPEN, S_PENDING, S_LOCKED} state_t;

  state_t           state_reg, state_next;
  logic             locked_reg, dirty_reg;
  logic             wr_fire, wr_hit, commit_fire, lock_fire;
  logic [WIDTH-1:0] shadow_reg [CHANNELS];
  logic [WIDTH-1:0] tie_reg    [CHANNELS];

  assign wr.ready    = !locked_reg;
  assign wr_fire     = wr.valid && wr.ready;
  // Out-of-range indices complete the handshake but touch nothing.
  assign wr_hit      = wr_fire && (32'(wr.addr) < CHANNELS);
  assign commit_fire = commit && (state_reg != S_LOCKED);
  assign lock_fire   = lock && (state_reg != S_LOCKED);
  assign locked      = locked_reg;
  assign dirty       = dirty_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_OPEN, S_PENDING: begin
        if (lock_fire)
          state_next = S_LOCKED;
        else if (wr_hit)
          state_next = S_PENDING;
        else if (commit_fire)
          state_next = S_OPEN;
      end
      default: state_next = S_LOCKED;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_reg  <= S_OPEN;
      locked_reg <= 1'b0;
      dirty_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      locked_reg <= (state_next == S_LOCKED);
      dirty_reg  <= (state_next == S_PENDING);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
          shadow_reg[gi] <= RESET_VALUE;
          tie_reg[gi]    <= RESET_VALUE;
        end else begin
          if (commit_fire)
            tie_reg[gi] <= shadow_reg[gi];
          // Locking collapses the shadow onto whatever ends up applied.
          if (lock_fire) begin
            if (!commit_fire)
              shadow_reg[gi] <= tie_reg[gi];
          end else if (wr_hit && (wr.addr == ADDR_W'(gi))) begin
            shadow_reg[gi] <= wr.data;
          end
        end
      end

      assign tie_out[gi*WIDTH +: WIDTH] = tie_reg[gi];

`ifdef TIE_CFG_PARITY_EN
      logic par_reg;
      always_ff @(posedge ck or posedge rst) begin
        if (rst)
          par_reg <= ^RESET_VALUE;
        else if (commit_fire)
          par_reg <= ^shadow_reg[gi];
      end
      assign par_out[gi] = par_reg;
`endif
    end
  endgenerate

endmodule
